accel_fir_16tap: RTL and testbench

Three-axis, 16-tap FIR filter sitting directly downstream of the SPI accelerometer reader in the signal path. It accepts one raw {x,y,z} sample set per `sample_valid`, shifts it into per-axis delay lines and computes each filtered axis on a single shared multiply-accumulate unit. Outputs are presented with a one-cycle `out_valid` strobe that drives the CPU data interrupt. Coefficients live in four selectable banks per axis and are written from the CPU update-control path.

---
 rtl/accel_fir_pkg.sv | 42 ++++
 rtl/accel_fir_coeff_ram.sv | 36 +++
 rtl/accel_fir_16tap.sv | 147 ++++++++++++++
 tb/tb_accel_fir_16tap.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_fir_pkg.sv
// Shared constants, FSM state and axis enums for the 3-axis FIR.
// round_sat: Q15 rounding right-shift with 16-bit saturation.
package accel_fir_pkg;

  localparam int NUM_TAPS  = 16;
  localparam int NUM_BANKS = 4;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC_X,
    S_MAC_Y,
    S_MAC_Z,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_t;

  localparam logic signed [ACC_W-1:0] RND  = 36'sd16384;
  localparam logic signed [ACC_W-1:0] MAXV = 36'sd32767;
  localparam logic signed [ACC_W-1:0] MINV = -36'sd32768;

  function automatic logic [DATA_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> 15;
    if (r > MAXV)
      round_sat = 16'h7fff;
    else if (r < MINV)
      round_sat = 16'h8000;
    else
      round_sat = r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/accel_fir_coeff_ram.sv
// Coefficient store, 3 axes x 4 banks x 16 taps, sync write, comb read.
// Ports: w_* write port (axis 3 ignored), r_* read address -> r_data.
module accel_fir_coeff_ram
  import accel_fir_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        w_axis,
  input  logic [1:0]        w_bank,
  input  logic [3:0]        w_tap,
  input  logic [DATA_W-1:0] w_data,
  input  logic [1:0]        r_axis,
  input  logic [1:0]        r_bank,
  input  logic [3:0]        r_tap,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [3][NUM_BANKS][NUM_TAPS];

  // Reset image: bank 0 tap 0 = 0x7FFF (near passthrough).
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < NUM_BANKS; b++)
          for (int t = 0; t < NUM_TAPS; t++)
            mem[a][b][t] <= (b == 0 && t == 0) ?
                            16'h7fff : '0;
    end else if (we && w_axis != 2'd3) begin
      mem[w_axis][w_bank][w_tap] <= w_data;
    end
  end

  assign r_data = mem[r_axis][r_bank][r_tap];

endmodule

// File: rtl/accel_fir_16tap.sv
// Three-axis 16-tap FIR on one shared MAC; 51-cycle sample period.
// Ports: sample in/strobe, bank selects, coeff update, outputs+status.
module accel_fir_16tap
  import accel_fir_pkg::*;
(
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic [15:0] z_in,
  input  logic [1:0]  x_bank,
  input  logic [1:0]  y_bank,
  input  logic [1:0]  z_bank,
  input  logic        update_en,
  input  logic [1:0]  update_axis,
  input  logic [1:0]  update_bank,
  input  logic [3:0]  update_index,
  input  logic [15:0] update_value,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  state_t state_q, state_d;
  axis_t  mac_axis;

  logic [3:0]        tap_q;
  logic [DATA_W-1:0] smp_q  [3];
  logic [1:0]        bank_q [3];
  logic [DATA_W-1:0] dl_q   [3][NUM_TAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic [DATA_W-1:0] x_q, y_q, z_q;
  logic              ovr_q;

  logic [DATA_W-1:0] cur_d, coef;
  logic signed [31:0] prod;
  logic signed [ACC_W-1:0] prod_ext, sum;
  logic mac_on, last_tap, accept;

  assign accept   = (state_q == S_IDLE) && sample_valid;
  assign last_tap = (tap_q == 4'd15);
  assign mac_on   = (state_q == S_MAC_X) ||
                    (state_q == S_MAC_Y) ||
                    (state_q == S_MAC_Z);

  always_comb begin
    state_d  = state_q;
    mac_axis = AX_X;
    unique case (state_q)
      S_IDLE:  if (sample_valid) state_d = S_SHIFT;
      S_SHIFT: state_d = S_MAC_X;
      S_MAC_X: if (last_tap) state_d = S_MAC_Y;
      S_MAC_Y: begin
        mac_axis = AX_Y;
        if (last_tap) state_d = S_MAC_Z;
      end
      S_MAC_Z: begin
        mac_axis = AX_Z;
        if (last_tap) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  accel_fir_coeff_ram u_coef (
    .sys_clk (sys_clk),
    .reset   (reset),
    .we      (update_en),
    .w_axis  (update_axis),
    .w_bank  (update_bank),
    .w_tap   (update_index),
    .w_data  (update_value),
    .r_axis  (mac_axis),
    .r_bank  (bank_q[mac_axis]),
    .r_tap   (tap_q),
    .r_data  (coef)
  );

  // Sign-extend to 32 bits; low 32 bits of the product are exact.
  assign cur_d = dl_q[mac_axis][tap_q];
  assign prod  = $signed({{16{cur_d[15]}}, cur_d}) *
                 $signed({{16{coef[15]}}, coef});
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  // Tap 0 starts a fresh accumulation.
  assign sum = (tap_q == 4'd0 ? '0 : acc_q) + prod_ext;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ovr_q   <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        smp_q[a]  <= '0;
        bank_q[a] <= '0;
        for (int t = 0; t < NUM_TAPS; t++)
          dl_q[a][t] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (sample_valid && state_q != S_IDLE)
        ovr_q <= 1'b1;
      if (accept) begin
        smp_q[0]  <= x_in;
        smp_q[1]  <= y_in;
        smp_q[2]  <= z_in;
        bank_q[0] <= x_bank;
        bank_q[1] <= y_bank;
        bank_q[2] <= z_bank;
      end
      if (state_q == S_SHIFT) begin
        for (int a = 0; a < 3; a++) begin
          dl_q[a][0] <= smp_q[a];
          for (int t = 1; t < NUM_TAPS; t++)
            dl_q[a][t] <= dl_q[a][t-1];
        end
      end
      if (mac_on) begin
        tap_q <= tap_q + 4'd1;
        acc_q <= sum;
        if (last_tap) begin
          case (mac_axis)
            AX_X:    x_q <= round_sat(sum);
            AX_Y:    y_q <= round_sat(sum);
            default: z_q <= round_sat(sum);
          endcase
        end
      end
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_accel_fir_16tap.sv
// Self-checking bench for accel_fir_16tap: vector table, corner
// sequences and random samples against a sum-of-products model.
module tb_accel_fir_16tap;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] x_in, y_in, z_in;
  logic [1:0]  x_bank, y_bank, z_bank;
  logic        update_en;
  logic [1:0]  update_axis, update_bank;
  logic [3:0]  update_index;
  logic [15:0] update_value;
  logic [15:0] x_out, y_out, z_out;
  logic        out_valid, busy, overrun;

  always #5 sys_clk = ~sys_clk;

  accel_fir_16tap dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .x_bank       (x_bank),
    .y_bank       (y_bank),
    .z_bank       (z_bank),
    .update_en    (update_en),
    .update_axis  (update_axis),
    .update_bank  (update_bank),
    .update_index (update_index),
    .update_value (update_value),
    .x_out        (x_out),
    .y_out        (y_out),
    .z_out        (z_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic [15:0] x, y, z;
    int          ex, ey, ez;
  } vec_t;

  vec_t   tbl [4];
  int     n_run = 0;
  int     n_fail = 0;
  int     cyc = 0;
  longint cm [3][4][16];
  longint hist [3][16];
  longint exp_o [3];

  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name,
                     input longint act,
                     input longint req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint rsat(input longint acc);
    longint r;
    r = (acc + 16384) >>> 15;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < 16; k++)
          cm[a][b][k] = 0;
      cm[a][0][0] = 32767;
      for (int k = 0; k < 16; k++)
        hist[a][k] = 0;
    end
  endtask

  task automatic model_accept(input longint sx, sy, sz,
                              input int bx, by, bz);
    longint s [3];
    int     b [3];
    longint acc;
    s[0] = sx; s[1] = sy; s[2] = sz;
    b[0] = bx; b[1] = by; b[2] = bz;
    for (int a = 0; a < 3; a++) begin
      for (int k = 15; k > 0; k--)
        hist[a][k] = hist[a][k-1];
      hist[a][0] = s[a];
      acc = 0;
      for (int k = 0; k < 16; k++)
        acc += hist[a][k] * cm[a][b[a]][k];
      exp_o[a] = rsat(acc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    update_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int a, b, i,
                            input logic [15:0] v);
    update_axis  = 2'(a);
    update_bank  = 2'(b);
    update_index = 4'(i);
    update_value = v;
    update_en    = 1'b1;
    tick();
    update_en    = 1'b0;
    if (a < 3) cm[a][b][i] = s16(v);
  endtask

  // Leaves the bench at T+1 with cyc = 1.
  task automatic start(input logic [15:0] x, y, z);
    x_in = x;
    y_in = y;
    z_in = z;
    sample_valid = 1'b1;
    model_accept(s16(x), s16(y), s16(z),
                 int'(x_bank), int'(y_bank), int'(z_bank));
    cyc = 0;
    tick();
    sample_valid = 1'b0;
    chk("busy_T1", busy, 1);
  endtask

  task automatic advance_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic finish(input string tag);
    while (!out_valid && cyc < 60) tick();
    chk({tag, " latency"}, cyc, 50);
    chk({tag, " x"}, s16(x_out), exp_o[0]);
    chk({tag, " y"}, s16(y_out), exp_o[1]);
    chk({tag, " z"}, s16(z_out), exp_o[2]);
    tick();
    chk({tag, " valid_drop"}, out_valid, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int extra;
    tbl[0] = '{16'd1000, 16'hFC18, 16'd0, 1000, -1000, 0};
    tbl[1] = '{16'h7FFF, 16'h8000, 16'd1,
               32766, -32767, 1};
    tbl[2] = '{16'hFFFF, 16'd2, 16'hFFFE, -1, 2, -2};
    tbl[3] = '{16'd100, 16'hFF9C, 16'd12345,
               100, -100, 12345};

    x_in = '0; y_in = '0; z_in = '0;
    x_bank = '0; y_bank = '0; z_bank = '0;
    update_axis = '0; update_bank = '0;
    update_index = '0; update_value = '0;
    do_reset();

    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst overrun", overrun, 0);
    chk("rst x_out", x_out, 0);
    chk("rst y_out", y_out, 0);
    chk("rst z_out", z_out, 0);

    for (int i = 0; i < 4; i++) begin
      start(tbl[i].x, tbl[i].y, tbl[i].z);
      finish("tbl");
      chk("tbl const x", s16(x_out), tbl[i].ex);
      chk("tbl const y", s16(y_out), tbl[i].ey);
      chk("tbl const z", s16(z_out), tbl[i].ez);
    end

    // Impulse through x bank 2 with ramp coefficients.
    do_reset();
    for (int k = 0; k < 16; k++)
      write_coef(0, 2, k, 16'((k + 1) * 256));
    x_bank = 2'd2;
    for (int k = 0; k < 16; k++) begin
      start(k == 0 ? 16'h7FFF : 16'h0000, 16'd0, 16'd0);
      finish("imp");
      chk("imp ramp", s16(x_out), (k + 1) * 256);
    end

    // Saturation on y bank 1.
    for (int k = 0; k < 16; k++)
      write_coef(1, 1, k, 16'h7FFF);
    y_bank = 2'd1;
    for (int k = 0; k < 16; k++) begin
      start(16'd7, 16'h7FFF, 16'd3);
      finish("satp");
    end
    chk("sat pos", y_out, 16'h7FFF);
    for (int k = 0; k < 16; k++) begin
      start(16'hFFF9, 16'h8000, 16'd5);
      finish("satn");
    end
    chk("sat neg", y_out, 16'h8000);

    // Dropped sample while busy.
    chk("ovr pre", overrun, 0);
    start(16'd1234, 16'd4321, 16'hF000);
    advance_to(20);
    x_in = 16'h5555; y_in = 16'h2222; z_in = 16'h1111;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    finish("ovr");
    chk("ovr flag", overrun, 1);
    extra = 0;
    repeat (12) begin
      tick();
      if (out_valid) extra++;
    end
    chk("ovr single", extra, 0);
    start(16'd10, 16'd20, 16'd30);
    finish("ovr hist");

    // Bank change and coefficient write mid-computation.
    for (int k = 0; k < 16; k++)
      write_coef(0, 3, k, 16'($urandom_range(0, 4095)));
    x_bank = 2'd0;
    start(16'd1000, 16'd0, 16'd0);
    advance_to(5);
    x_bank = 2'd3;
    write_coef(0, 0, 0, 16'h4000);
    finish("bank");
    x_bank = 2'd0;
    start(16'd1000, 16'd0, 16'd0);
    finish("live");
    chk("live const", s16(x_out), 500);

    // Reset in the middle of MAC_Y.
    start(16'd999, 16'd888, 16'd777);
    advance_to(25);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("mid busy", busy, 0);
    chk("mid x_out", x_out, 0);
    chk("mid y_out", y_out, 0);
    chk("mid z_out", z_out, 0);
    chk("mid overrun", overrun, 0);
    extra = 0;
    repeat (30) begin
      if (out_valid) extra++;
      tick();
    end
    chk("mid no valid", extra, 0);
    x_bank = '0; y_bank = '0; z_bank = '0;
    start(16'd1000, 16'hFC18, 16'd0);
    finish("mid post");
    chk("mid post x", s16(x_out), 1000);
    chk("mid post y", s16(y_out), -1000);

    // Random coefficients, banks and samples.
    for (int it = 0; it < 24; it++) begin
      write_coef(int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)),
                 16'($urandom_range(0, 8191)) - 16'd4096);
      x_bank = 2'($urandom);
      y_bank = 2'($urandom);
      z_bank = 2'($urandom);
      start(16'($urandom), 16'($urandom), 16'($urandom));
      finish("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
